// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction-fetch controller.
// State codes, default widths and reset values.
package ifetch_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_REQ  = 2'd1;
    localparam state_t S_HOLD = 2'd2;
    localparam state_t S_DROP = 2'd3;

    localparam state_t RST_STATE = S_IDLE;
    localparam logic   RST_REQ   = 1'b0;
    localparam logic   RST_VALID = 1'b0;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction memory req/ack bus.
// The fetch controller is the master, the memory the slave.
interface ifetch_ctrl_if
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/ifetch_skid.sv
// One-entry skid buffer holding an instruction and its PC.
// Catches an ack that arrives while the output slot is stalled.
module ifetch_skid
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              full_o
);

    // Entry storage: clear wipes contents, unload only frees the slot.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o <= '0;
            pc_o   <= '0;
            full_o <= RST_VALID;
        end else if (clear_i) begin
            data_o <= '0;
            pc_o   <= '0;
            full_o <= 1'b0;
        end else if (load_i) begin
            data_o <= data_i;
            pc_o   <= pc_i;
            full_o <= 1'b1;
        end else if (unload_i) begin
            full_o <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller between the PC and instruction memory.
// Runs req/ack fetches, buffers one extra word, handles stalls and flushes.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              stall_o,
    input  logic              flush_i,
    input  logic              id_stall_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    ifetch_ctrl_if.master     mem
);

    state_t            state_q;
    state_t            state_d;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ack;
    logic              slot_free;
    logic              latch;
    logic              wr_out;
    logic              wr_skid;
    logic              unload;
    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_pc;
    logic              skid_full;

    assign mem.req   = req_q;
    assign mem.addr  = addr_q;
    assign ack       = req_q & mem.ack;
    assign slot_free = ~inst_valid_o | ~id_stall_i;

    // Latch event, next state and data moves for this cycle.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        wr_out  = 1'b0;
        wr_skid = 1'b0;
        unload  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!flush_i && start_i)
                    latch = 1'b1;
            end
            S_REQ: begin
                if (flush_i) begin
                    state_d = ack ? S_IDLE : S_DROP;
                end else if (ack && slot_free) begin
                    wr_out = 1'b1;
                    latch  = 1'b1;
                end else if (ack) begin
                    wr_skid = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (!id_stall_i && skid_full) begin
                    unload = 1'b1;
                    latch  = 1'b1;
                end
            end
            S_DROP: begin
                if (flush_i)
                    state_d = S_IDLE;
                else if (ack)
                    latch = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (latch)
            state_d = S_REQ;
    end

    // PC advances only when its value is captured or on a redirect.
    assign stall_o = ~rst_i | ~(latch | flush_i);

    // FSM state and the registered memory request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RST_STATE;
            req_q   <= RST_REQ;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == S_REQ) || (state_d == S_DROP);
            if (latch)
                addr_q <= pc_i;
        end
    end

    // Output slot: fill from memory or skid, drain when consumed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= RST_VALID;
        end else if (flush_i) begin
            inst_valid_o <= 1'b0;
        end else if (wr_out) begin
            inst_o       <= mem.rdata;
            inst_pc_o    <= addr_q;
            inst_valid_o <= 1'b1;
        end else if (unload) begin
            inst_o       <= skid_data;
            inst_pc_o    <= skid_pc;
            inst_valid_o <= 1'b1;
        end else if (!id_stall_i) begin
            inst_valid_o <= 1'b0;
        end
    end

    ifetch_skid #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (wr_skid),
        .unload_i (unload),
        .clear_i  (flush_i),
        .data_i   (mem.rdata),
        .pc_i     (addr_q),
        .data_o   (skid_data),
        .pc_o     (skid_pc),
        .full_o   (skid_full)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl against a queue-level fetch model.
// Environment supplies a PC register and a variable-latency memory.
module tb_ifetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        stall_o;
    logic        flush_i;
    logic        id_stall_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;

    ifetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    ifetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .stall_o      (stall_o),
        .flush_i      (flush_i),
        .id_stall_i   (id_stall_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .mem          (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model: instructions held (output first, then skid) and request
    ent_t        q[$];
    ent_t        nq[$];
    bit          outst, n_outst;
    bit          drop, n_drop;
    logic [31:0] oaddr, n_oaddr;

    // environment state
    bit          prev_flush;
    bit          prev_stall;
    logic [31:0] tgt;
    bit          mem_pend;
    int          mem_wait;
    int          lat_max, stall_pct, flush_pct, start_pct;
    bit          first_flush;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req", mem_bus.req, 0);
        check("rst_addr", mem_bus.addr, 0);
        check("rst_inst", inst_o, 0);
        check("rst_ipc", inst_pc_o, 0);
        check("rst_valid", inst_valid_o, 0);
        check("rst_stall", stall_o, 1);
    endtask

    task automatic model_reset();
        q.delete();
        nq.delete();
        outst = 0;
        drop = 0;
        oaddr = '0;
        n_outst = 0;
        n_drop = 0;
        n_oaddr = '0;
        mem_pend = 0;
    endtask

    // Next model state from current inputs; returns whether PC is taken.
    task automatic mdl_eval(output bit lat);
        bit   ack_e;
        bit   prog;
        ent_t e;
        nq = q;
        n_outst = outst;
        n_drop = drop;
        n_oaddr = oaddr;
        lat = 0;
        prog = 0;
        ack_e = outst && mem_bus.ack;
        if (flush_i) begin
            nq.delete();
            if (outst && !drop && !ack_e) begin
                n_drop = 1;
            end else begin
                n_outst = 0;
                n_drop = 0;
            end
        end else begin
            if (nq.size() > 0 && !id_stall_i) begin
                if (nq.size() == 2) prog = 1;
                void'(nq.pop_front());
            end
            if (ack_e) begin
                n_outst = 0;
                if (!drop) begin
                    e.pc = oaddr;
                    e.data = memf(oaddr);
                    nq.push_back(e);
                end
                n_drop = 0;
                prog = 1;
            end
            if (!n_outst && nq.size() <= 1 && (start_i || prog)) begin
                lat = 1;
                n_outst = 1;
                n_oaddr = pc_i;
            end
        end
    endtask

    // Drive one cycle's inputs, then check the combinational stall.
    task automatic drive_half();
        bit lat;
        start_i = ($urandom_range(0, 99) < start_pct);
        id_stall_i = ($urandom_range(0, 99) < stall_pct);
        flush_i = ($urandom_range(0, 99) < flush_pct);
        mem_bus.ack = 1'b0;
        mem_bus.rdata = $urandom;
        if (!mem_bus.req) begin
            mem_pend = 0;
        end else if (!mem_pend) begin
            mem_pend = 1;
            mem_wait = $urandom_range(0, lat_max);
        end
        if (mem_pend && mem_wait == 0) begin
            mem_bus.ack = 1'b1;
            mem_bus.rdata = memf(mem_bus.addr);
            mem_pend = 0;
        end else begin
            if (mem_pend) mem_wait--;
            if (!mem_bus.req && $urandom_range(0, 7) == 0)
                mem_bus.ack = 1'b1;
        end
        #1;
        mdl_eval(lat);
        check("stall", stall_o, !(lat || flush_i));
        prev_flush = flush_i;
        prev_stall = stall_o;
        if (flush_i) begin
            if (first_flush) tgt = 32'h80;
            else tgt = $urandom_range(0, 4095) & ~32'h3;
            first_flush = 0;
        end
    endtask

    // Advance the clock, commit the model, check registered outputs.
    task automatic post_edge();
        @(posedge clk);
        #1;
        q = nq;
        outst = n_outst;
        drop = n_drop;
        oaddr = n_oaddr;
        if (prev_flush) pc_i = tgt;
        else if (!prev_stall) pc_i = pc_i + 32'd4;
        check("req", mem_bus.req, outst);
        if (outst) check("addr", mem_bus.addr, oaddr);
        check("valid", inst_valid_o, q.size() > 0);
        if (q.size() > 0) begin
            check("inst", inst_o, q[0].data);
            check("ipc", inst_pc_o, q[0].pc);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            post_edge();
            drive_half();
        end
    endtask

    task automatic knobs(input int lm, input int sp, input int fp,
                         input int st);
        lat_max = lm;
        stall_pct = sp;
        flush_pct = fp;
        start_pct = st;
    endtask

    initial begin
        int guard;
        rst_i = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        id_stall_i = 1'b0;
        pc_i = 32'h0;
        mem_bus.ack = 1'b0;
        mem_bus.rdata = '0;
        first_flush = 1;
        tgt = 32'h80;
        model_reset();
        #1;
        check_reset_vals();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;

        knobs(0, 0, 0, 100);
        drive_half();
        run(12);

        knobs(2, 0, 0, 100);
        run(20);

        knobs(3, 40, 0, 100);
        run(200);

        knobs(3, 30, 6, 90);
        run(1500);

        knobs(1, 60, 4, 70);
        run(800);

        knobs(4, 20, 0, 100);
        guard = 0;
        post_edge();
        while (!(mem_bus.req && mem_pend && mem_wait > 0) && guard < 200) begin
            drive_half();
            post_edge();
            guard++;
        end
        check("req_seen", guard < 200, 1);
        rst_i = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        model_reset();
        pc_i = 32'h40;
        knobs(3, 30, 5, 90);
        drive_half();
        run(800);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller that sits between the PC register and instruction memory. It takes the current PC, runs a req/ack fetch against a variable-latency instruction memory, and presents the fetched instruction to the IF/ID stage. It drives the PC's stall input so the PC advances exactly when a fetch address has been accepted. It also absorbs downstream stalls and branch flushes.

## Interface
- `ADDR_W`, default 32: fetch address width.
- `DATA_W`, default 32: instruction width.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: core run enable, same signal that gates the PC.
- `pc_i` in ADDR_W: current PC value from the PC register output.
- `stall_o` out 1: to the PC stall input; 1 holds the PC.
- `flush_i` in 1: branch taken or redirect. Drop in-flight and buffered instructions.
- `id_stall_i` in 1: IF/ID cannot consume this cycle.
- `inst_o` out DATA_W: fetched instruction.
- `inst_pc_o` out ADDR_W: address of `inst_o`.
- `inst_valid_o` out 1: `inst_o` holds a valid instruction.
- `mem_req_o` out 1: fetch request to instruction memory.
- `mem_addr_o` out ADDR_W: fetch address, stable while `mem_req_o`=1.
- `mem_ack_i` in 1: memory returns `mem_rdata_i`; one ack per request.
- `mem_rdata_i` in DATA_W: instruction data, valid with `mem_ack_i`.

## Operation
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - HOLD: data buffered in the skid register, output slot full.
  - DROP: flushed request outstanding, data will be discarded.
- Latch event L: the controller captures `pc_i` into `mem_addr_o` and enters REQ. `stall_o` is 0 exactly in cycles where L occurs, or where `flush_i`=1. Otherwise `stall_o`=1.
- L occurs on:
  - IDLE with `start_i`=1.
  - REQ with `mem_ack_i`, when the slot is free (`~inst_valid_o | ~id_stall_i`).
  - HOLD with `~id_stall_i`.
  - DROP with `mem_ack_i`.
  - In all cases only if `flush_i`=0.
- REQ + `mem_ack_i`, slot free: write `inst_o`/`inst_pc_o` from the data and `mem_addr_o`, set `inst_valid_o`, then L. Back-to-back requests keep `mem_req_o`=1.
- REQ + `mem_ack_i`, slot busy: write the skid register, `mem_req_o`→0, go to HOLD.
- HOLD + `~id_stall_i`: move skid→output, then L.
- Output consumption: `inst_valid_o` clears at any edge with `id_stall_i`=0 and no new write.
- `flush_i` has the highest priority:
  - `inst_valid_o`→0 and the skid register is cleared.
  - No L occurs that cycle; `pc_i` is stale.
  - REQ without ack → DROP.
  - Every other state → IDLE.
  - An ack in the flush cycle is discarded.
- DROP discards its ack data.
- `start_i`=0: no new L occurs from IDLE. An outstanding request still completes.

## Timing
- Reset values: state IDLE, `mem_req_o`=0, `mem_addr_o`=0, `inst_o`=0, `inst_pc_o`=0, `inst_valid_o`=0, skid=0. `stall_o` is forced to 1 while `rst_i`=0.
- `mem_req_o` and `mem_addr_o` are registered, so the earliest ack is 1 cycle after the request rises.
- `stall_o` is combinational from state, `mem_ack_i`, `id_stall_i`, `flush_i` and `start_i`.
- Throughput: 1 instruction/cycle with a zero-wait memory (ack in every REQ cycle) and no stalls.
- Latency: `pc_i` latched at edge n; ack in cycle n+k; `inst_valid_o`=1 from edge n+k+1.
- Reset mid-transaction aborts immediately. The memory must tolerate the dropped request.
- `mem_ack_i` is ignored when `mem_req_o`=0.

## Structure
- Package `ifetch_pkg` holds:
  - the state enum (IDLE/REQ/HOLD/DROP);
  - `ADDR_W`/`DATA_W` defaults;
  - the reset constants.
- Sub-module `ifetch_skid`: one-entry data+pc buffer with load, unload and clear.
- The FSM and output register stay in `ifetch_ctrl`.

## Test plan
- Zero-wait memory, `start_i`=1, PC stepping 0,4,8: `mem_addr_o`=0,4,8 on consecutive cycles. `inst_valid_o` is continuous from cycle 2, `stall_o` is always 0, and `inst_pc_o` matches `mem_addr_o` delayed by one cycle.
- Ack latency 3 at pc=0x10: `stall_o`=1 for 2 cycles, `mem_req_o` stays high with addr 0x10, then `inst_o`=`mem_rdata_i` and `inst_pc_o`=0x10.
- `id_stall_i`=1 for 4 cycles with the output full and an ack arriving: HOLD is entered and `stall_o`=1. When the stall releases, the skid value appears on `inst_o` and the next address is latched.
- `flush_i` at pc=0x20 while a request is waiting: DROP, the ack data is never visible, and the next request uses branch target 0x80.
- `flush_i` in HOLD: `inst_valid_o`=0 next cycle, IDLE, then a refetch from the new `pc_i`.
- `rst_i` low mid-request: all outputs at reset values within the same cycle and `stall_o`=1. After release, fetching restarts from `pc_i`.
